// File: rtl/ram_dual_sync_if.sv
// Bus bundle for ram_dual_sync: write port, read port, status and FSM debug state.
// Handshake: a request is taken on any posedge where we/re is high and busy is low; rvalid strobes one result per taken read.
interface ram_dual_sync_if #(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 7
);
    localparam int NLANE = DATA_W / BYTE_W;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [NLANE-1:0]  wbe;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;
    logic              rerr;
    logic              dbg_state;

    modport master (
        output we, waddr, wdata, wbe, re, raddr,
        input  rdata, rvalid, busy, rerr, dbg_state
    );

    modport slave (
        input  we, waddr, wdata, wbe, re, raddr,
        output rdata, rvalid, busy, rerr, dbg_state
    );
endinterface

// File: rtl/ram_dual_sync.sv
// Simple dual-port RAM with byte lanes, clear-after-reset sweep, optional output stage.
// Optional per-lane even parity is enabled by defining RAM_PARITY_EN.
module ram_dual_sync #(
    parameter int DATA_W  = 32,
    parameter int BYTE_W  = 8,
    parameter int ADDR_W  = 7,
    parameter int OUT_REG = 0,
    parameter int BYPASS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_dual_sync_if.slave  bus
);
    localparam int NLANE = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LW = BYTE_W + PAR;
    localparam int MW = NLANE * LW;

    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              last;
    logic              busy;
    logic              wr_fire, rd_fire;
    logic [MW-1:0]     wr_enc, rd_word;
    logic              out_valid;
    logic [MW-1:0]     out_word;
    logic              out_err;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q, rerr_q;

    logic [MW-1:0] mem [DEPTH];

    // Stored lane layout: data in the low BYTE_W bits, parity (if any) on top.
    function automatic logic [MW-1:0] encode(input logic [DATA_W-1:0] d);
        logic [MW-1:0] w;
        w = '0;
        for (int i = 0; i < NLANE; i++) begin
            w[i*LW +: BYTE_W] = d[i*BYTE_W +: BYTE_W];
`ifdef RAM_PARITY_EN
            w[i*LW + BYTE_W] = ^d[i*BYTE_W +: BYTE_W];
`endif
        end
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] decode(input logic [MW-1:0] w);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < NLANE; i++) d[i*BYTE_W +: BYTE_W] = w[i*LW +: BYTE_W];
        return d;
    endfunction

`ifdef RAM_PARITY_EN
    function automatic logic par_err(input logic [MW-1:0] w);
        logic e;
        e = 1'b0;
        for (int i = 0; i < NLANE; i++) e = e | ((^w[i*LW +: BYTE_W]) ^ w[i*LW + BYTE_W]);
        return e;
    endfunction
`endif

    assign last = (cnt == {ADDR_W{1'b1}});

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_CLEAR;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && last) state_nxt = ST_READY;
    end

    // FSM: outputs
    always_comb begin
        busy = (state == ST_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= '0;
        else if (busy && !last)      cnt <= cnt + 1'b1;
    end

    assign wr_fire = bus.we & ~busy;
    assign rd_fire = bus.re & ~busy;
    assign wr_enc  = encode(bus.wdata);

    // Same-address collision: merge the enabled new lanes over the old word.
    always_comb begin
        rd_word = mem[bus.raddr];
        if (BYPASS != 0 && wr_fire && bus.waddr == bus.raddr) begin
            for (int i = 0; i < NLANE; i++)
                if (bus.wbe[i]) rd_word[i*LW +: LW] = wr_enc[i*LW +: LW];
        end
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NLANE; i++)
                if (bus.wbe[i]) mem[bus.waddr][i*LW +: LW] <= wr_enc[i*LW +: LW];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          p_valid;
            logic [MW-1:0] p_word;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_valid <= 1'b0;
                    p_word  <= '0;
                end else begin
                    p_valid <= rd_fire;
                    if (rd_fire) p_word <= rd_word;
                end
            end
            assign out_valid = p_valid;
            assign out_word  = p_word;
        end else begin : g_no_out_reg
            assign out_valid = rd_fire;
            assign out_word  = rd_word;
        end
    endgenerate

`ifdef RAM_PARITY_EN
    assign out_err = par_err(out_word);
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            rvalid_q <= out_valid;
            rerr_q   <= out_valid & out_err;
            if (out_valid) rdata_q <= decode(out_word);
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rerr      = rerr_q;
    assign bus.busy      = busy;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_ram_dual_sync.sv
// Directed bench for ram_dual_sync: clear sweep, byte lanes, collision, pipelining, reset abort, parity.
module tb_ram_dual_sync;
    localparam int DATA_W  = 32;
    localparam int BYTE_W  = 8;
    localparam int ADDR_W  = 7;
    localparam int OUT_REG = 0;
    localparam int BYPASS  = 1;
    localparam int LAT     = OUT_REG + 1;
`ifdef RAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [DATA_W-1:0] exp_q[$];

    ram_dual_sync_if #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) bus ();

    ram_dual_sync #(
        .DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W),
        .OUT_REG(OUT_REG), .BYPASS(BYPASS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drivers
    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [3:0] be);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d; bus.wbe = be;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic wait_rvalid(output int lat);
        lat = 1;
        while (!bus.rvalid && lat < 6) begin
            tick();
            lat++;
        end
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                             output logic e, output int lat);
        bus.re = 1'b1; bus.raddr = a;
        tick();
        bus.re = 1'b0;
        wait_rvalid(lat);
        d = bus.rdata;
        e = bus.rerr;
    endtask

    task automatic count_busy(output int n, output int seen);
        n = 0; seen = 0;
        while (bus.busy && n < 300) begin
            tick();
            n++;
            if (bus.rvalid) seen++;
        end
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] d; logic e; int lat, n, seen;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0); end
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
        checks++; if (bus.rerr !== 1'b0) begin failures++; $display("FAIL reset_rerr got=%b exp=0", bus.rerr); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
        tick(); tick();
        rst_n = 1'b1;
        count_busy(n, seen);
        checks++; if (n !== 128) begin failures++; $display("FAIL sweep_len got=%0d exp=128", n); end
        read_word(7'd0, d, e, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rd0_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rd0_data got=%h exp=%h", d, 32'h0); end
        read_word(7'd127, d, e, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rd127_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rd127_data got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_byte_lanes();
        logic [DATA_W-1:0] d; logic e; int lat;
        write_word(7'd5, 32'h11223344, 4'hF);
        write_word(7'd5, 32'hDEADBEEF, 4'b0101);
        read_word(7'd5, d, e, lat);
        checks++; if (d !== 32'h11AD33EF) begin failures++; $display("FAIL lane_merge got=%h exp=%h", d, 32'h11AD33EF); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL lane_rerr got=%b exp=0", e); end
        write_word(7'd5, 32'hFFFFFFFF, 4'h0);
        read_word(7'd5, d, e, lat);
        checks++; if (d !== 32'h11AD33EF) begin failures++; $display("FAIL wbe_zero got=%h exp=%h", d, 32'h11AD33EF); end
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] d, exp_d; logic e; int lat;
        write_word(7'd9, 32'hAAAAAAAA, 4'hF);
        bus.we = 1'b1; bus.waddr = 7'd9; bus.wdata = 32'h55555555; bus.wbe = 4'b0011;
        bus.re = 1'b1; bus.raddr = 7'd9;
        tick();
        bus.we = 1'b0; bus.re = 1'b0;
        wait_rvalid(lat);
        exp_d = (BYPASS != 0) ? 32'hAAAA5555 : 32'hAAAAAAAA;
        checks++; if (bus.rdata !== exp_d) begin failures++; $display("FAIL collide_data got=%h exp=%h", bus.rdata, exp_d); end
        read_word(7'd9, d, e, lat);
        checks++; if (d !== 32'hAAAA5555) begin failures++; $display("FAIL collide_after got=%h exp=%h", d, 32'hAAAA5555); end
        write_word(7'd10, 32'h13579BDF, 4'hF);
        bus.we = 1'b1; bus.waddr = 7'd11; bus.wdata = 32'hFFFFFFFF; bus.wbe = 4'hF;
        bus.re = 1'b1; bus.raddr = 7'd10;
        tick();
        bus.we = 1'b0; bus.re = 1'b0;
        wait_rvalid(lat);
        checks++; if (bus.rdata !== 32'h13579BDF) begin failures++; $display("FAIL other_addr got=%h exp=%h", bus.rdata, 32'h13579BDF); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] vals [3];
        logic [DATA_W-1:0] exp_d;
        int first, last_c, nvalid;
        vals[0] = 32'hA1A1A1A1; vals[1] = 32'hB2B2B2B2; vals[2] = 32'hC3C3C3C3;
        for (int i = 0; i < 3; i++) write_word(ADDR_W'(i + 1), vals[i], 4'hF);
        tick();
        first = -1; last_c = -1; nvalid = 0;
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                bus.re = 1'b1; bus.raddr = ADDR_W'(c + 1);
                exp_q.push_back(vals[c]);
            end else begin
                bus.re = 1'b0;
            end
            tick();
            if (bus.rvalid) begin
                if (first < 0) first = c;
                last_c = c;
                nvalid++;
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
                checks++; if (bus.rdata !== exp_d) begin failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, bus.rdata, exp_d); end
            end
        end
        checks++; if (first !== LAT - 1) begin failures++; $display("FAIL b2b_first got=%0d exp=%0d", first, LAT - 1); end
        checks++; if (nvalid !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", nvalid); end
        checks++; if (last_c - first !== 2) begin failures++; $display("FAIL b2b_contig got=%0d exp=2", last_c - first); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d; logic e; int lat, n, seen;
        bus.re = 1'b1; bus.raddr = 7'd1;
        tick();
        bus.re = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL abort_rvalid got=%b exp=0", bus.rvalid); end
        tick();
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL abort_pending got=%b exp=0", bus.rvalid); end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        #2 rst_n = 1'b0;
        #2;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
        rst_n = 1'b1;
        bus.we = 1'b1; bus.waddr = 7'd0; bus.wdata = 32'hFFFFFFFF; bus.wbe = 4'hF;
        bus.re = 1'b1; bus.raddr = 7'd0;
        count_busy(n, seen);
        bus.we = 1'b0; bus.re = 1'b0;
        checks++; if (n !== 128) begin failures++; $display("FAIL mid_sweep_len got=%0d exp=128", n); end
        checks++; if (seen !== 0) begin failures++; $display("FAIL busy_rvalid got=%0d exp=0", seen); end
        read_word(7'd0, d, e, lat);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL busy_write_lost got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_parity();
        logic [DATA_W-1:0] d; logic e; int lat;
        write_word(7'd7, 32'h12345678, 4'hF);
        #2 dut.mem[7][0] = ~dut.mem[7][0];
        read_word(7'd7, d, e, lat);
        checks++; if (d !== 32'h12345679) begin failures++; $display("FAIL par_data got=%h exp=%h", d, 32'h12345679); end
        checks++; if (e !== PAR_EN) begin failures++; $display("FAIL par_rerr got=%b exp=%b", e, PAR_EN); end
        tick();
        checks++; if (bus.rerr !== 1'b0) begin failures++; $display("FAIL par_rerr_clear got=%b exp=0", bus.rerr); end
    endtask

    initial begin
        checks = 0; failures = 0;
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wbe = '0;
        bus.re = 1'b0; bus.raddr = '0;
        test_reset();
        test_byte_lanes();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
